// File: rtl/uproc_pkg.sv
// uproc_pkg: shared micro-processor constants and fetch-stage types
package uproc_pkg;
    localparam int INS_W = 13;
    localparam int PM_DEPTH = 256;
    localparam logic [4:0] OPCODE_HALT = 5'b11111;
    typedef enum logic [1:0] {IDLE, PRIME, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/program_counter.sv
// program_counter: fetch address register with clear, load-enable and wrap at DEPTH-1
module program_counter
    import uproc_pkg::*;
#(
    parameter int DEPTH = PM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              ld,
    output logic [ADDR_W-1:0] addr
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0] addr_q, addr_d;
    always_comb addr_d = clr ? '0 : ld ? (addr_q == LAST ? '0 : addr_q + 1'b1) : addr_q;
    always_ff @(posedge clk) begin
        if (!rst_n) addr_q <= '0;
        else addr_q <= addr_d;
    end
    assign addr = addr_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch FSM and instruction register feeding the decoder
module instruction_fetch_unit
    import uproc_pkg::*;
#(
    parameter int INS_W = uproc_pkg::INS_W,
    parameter int PM_DEPTH = uproc_pkg::PM_DEPTH,
    parameter int ADDR_W = $clog2(PM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              stall,
    input  logic              restart,
    output logic [ADDR_W-1:0] pm_addr,
    input  logic [INS_W-1:0]  pm_rdata,
    output logic [INS_W-1:0]  ins,
    output logic              ins_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    fetch_state_t state_q, state_d;
    logic [INS_W-1:0] ins_q, ins_d;
    logic [ADDR_W-1:0] pc_q, pc_d, fetch_addr;
    logic ins_valid_q, ins_valid_d, halted_q, halted_d;
    logic pc_clr, pc_ld, is_halt;
    assign is_halt = pm_rdata[INS_W-1 -: 5] == OPCODE_HALT;
    program_counter #(.DEPTH(PM_DEPTH), .ADDR_W(ADDR_W)) u_pc (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (pc_clr),
        .ld   (pc_ld),
        .addr (fetch_addr)
    );
    always_comb begin
        state_d = state_q;
        ins_d = ins_q;
        pc_d = pc_q;
        ins_valid_d = ins_valid_q;
        halted_d = halted_q;
        pc_clr = 1'b0;
        pc_ld = 1'b0;
        case (state_q)
            IDLE: begin
                pc_clr = 1'b1;
                state_d = en ? PRIME : IDLE;
            end
            PRIME: begin
                ins_d = pm_rdata;
                pc_d = fetch_addr;
                pc_ld = 1'b1;
                ins_valid_d = 1'b1;
                state_d = RUN;
            end
            RUN: if (!stall) begin
                ins_d = pm_rdata;
                pc_d = fetch_addr;
                pc_ld = !is_halt;
                ins_valid_d = !is_halt;
                halted_d = is_halt;
                state_d = is_halt ? HALT : RUN;
            end
            HALT: if (restart) begin
                pc_clr = 1'b1;
                halted_d = 1'b0;
                ins_valid_d = 1'b0;
                state_d = PRIME;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ins_q <= '0;
            pc_q <= '0;
            ins_valid_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ins_q <= ins_d;
            pc_q <= pc_d;
            ins_valid_q <= ins_valid_d;
            halted_q <= halted_d;
        end
    end
    assign pm_addr = fetch_addr;
    assign ins = ins_q;
    assign ins_valid = ins_valid_q;
    assign pc = pc_q;
    assign halted = halted_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized scoreboard bench against an instruction-stream model
module tb_instruction_fetch_unit;
    localparam int DEPTH = 12;
    localparam int AW = 4;
    localparam logic [4:0] HALT_OP = 5'h1F;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, stall = 1'b0, restart = 1'b0;
    logic [AW-1:0] pm_addr, pc;
    logic [12:0] pm_rdata, ins;
    logic ins_valid, halted;
    logic [12:0] mem [0:15];
    typedef struct {bit h; int pc; logic [12:0] ins; int pm;} item_t;
    item_t q[$];
    int total = 0, bad = 0;
    int gen_a = 0;
    bit gen_first = 1'b0, gen_done = 1'b1;
    always #5 clk = ~clk;
    assign pm_rdata = mem[pm_addr];
    instruction_fetch_unit #(.PM_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .stall    (stall),
        .restart  (restart),
        .pm_addr  (pm_addr),
        .pm_rdata (pm_rdata),
        .ins      (ins),
        .ins_valid(ins_valid),
        .pc       (pc),
        .halted   (halted)
    );
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", n, got, exp, $time);
        end
    endtask
    function automatic logic [12:0] rand_word();
        logic [12:0] w = 13'($urandom);
        if (w[12:8] == HALT_OP) w[8] = 1'b0;
        return w;
    endfunction
    task automatic fill_mem(input int h);
        for (int i = 0; i < 16; i++) mem[i] = rand_word();
        if (h >= 0) mem[h] = 13'h1F00 | 13'($urandom_range(0, 255));
    endtask
    task automatic top_up();
        item_t it;
        while (!gen_done && q.size() < 4) begin
            it.pc = gen_a;
            it.ins = mem[gen_a];
            it.h = !gen_first && mem[gen_a][12:8] == HALT_OP;
            it.pm = it.h ? gen_a : (gen_a + 1) % DEPTH;
            q.push_back(it);
            gen_done = it.h;
            gen_a = (gen_a + 1) % DEPTH;
            gen_first = 1'b0;
        end
    endtask
    task automatic begin_stream();
        gen_a = 0;
        gen_first = 1'b1;
        gen_done = 1'b0;
        top_up();
    endtask
    task automatic step();
        stall = ($urandom_range(0, 3) == 0);
        restart = !halted && ($urandom_range(0, 15) == 0);
        en = ($urandom_range(0, 15) == 0);
        top_up();
        @(posedge clk);
        #1;
        restart = 1'b0;
        en = 1'b0;
    endtask
    task automatic start();
        begin_stream();
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        stall = 1'($urandom_range(0, 1));
        chk("prime_not_valid", 32'(ins_valid), 0);
        @(posedge clk);
        #1;
        chk("start_latency", 32'({ins_valid, pc}), 32'({1'b1, 4'd0}));
    endtask
    task automatic run_until_halt();
        int n = 0;
        while (!halted && n < 200) begin
            step();
            n++;
        end
        chk("halt_reached", 32'(halted), 1);
    endtask
    task automatic do_reset();
        gen_done = 1'b1;
        stall = 1'b0;
        en = 1'b0;
        restart = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("idle_no_fetch", 32'({ins_valid, halted, pm_addr, pc}), 0);
        end
    endtask
    logic prev_rst = 1'b0, prev_valid = 1'b0, prev_stall = 1'b0, prev_halted = 1'b0;
    logic [AW-1:0] prev_pc = '0, prev_pm = '0;
    logic [12:0] prev_ins = '0;
    always @(negedge clk) begin : monitor
        item_t it;
        if (!prev_rst) begin
            chk("reset_state", 32'({ins, pc, pm_addr, ins_valid, halted}), 0);
            q.delete();
        end else if (ins_valid && !(prev_valid && prev_stall)) begin
            if (q.size() == 0) chk("spurious_ins", 32'(ins_valid), 0);
            else begin
                it = q.pop_front();
                chk("ins_not_halt", 32'(it.h), 0);
                chk("pc", 32'(pc), it.pc);
                chk("ins", 32'(ins), 32'(it.ins));
                chk("pm_addr", 32'(pm_addr), it.pm);
            end
        end else if (ins_valid) begin
            chk("stall_hold", 32'({ins, pc, pm_addr}), 32'({prev_ins, prev_pc, prev_pm}));
        end else if (halted && !prev_halted) begin
            if (q.size() == 0) chk("spurious_halt", 32'(halted), 0);
            else begin
                it = q.pop_front();
                chk("halt_expected", 32'(it.h), 1);
                chk("halt_pc", 32'(pc), it.pc);
                chk("halt_ins", 32'(ins), 32'(it.ins));
                chk("halt_pm_addr", 32'(pm_addr), it.pc);
            end
        end else if (halted) begin
            chk("halt_hold", 32'({ins_valid, ins, pc, pm_addr}), 32'({1'b0, prev_ins, prev_pc, prev_pm}));
        end
        prev_rst = rst_n;
        prev_valid = ins_valid;
        prev_stall = stall;
        prev_halted = halted;
        prev_pc = pc;
        prev_pm = pm_addr;
        prev_ins = ins;
    end
    initial begin
        int n;
        fill_mem(-1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("idle_after_reset", 32'({ins_valid, halted, pm_addr}), 0);
        end
        for (int iter = 0; iter < 4; iter++) begin
            fill_mem(-1);
            start();
            n = 0;
            while (n < 200 && !(n >= 2 * DEPTH && pc == 4'd7 && ins_valid)) begin
                step();
                n++;
            end
            chk("reach_pc7", 32'(pc), 7);
            do_reset();
            fill_mem($urandom_range(1, DEPTH - 1));
            start();
            run_until_halt();
            repeat (3) begin
                stall = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            chk("still_halted", 32'(halted), 1);
            begin_stream();
            restart = 1'b1;
            @(posedge clk);
            #1;
            restart = 1'b0;
            chk("restart_clears", 32'({halted, ins_valid}), 0);
            @(posedge clk);
            #1;
            chk("restart_latency", 32'({ins_valid, pc}), 32'({1'b1, 4'd0}));
            run_until_halt();
            do_reset();
        end
        fill_mem(4);
        start();
        stall = 1'b0;
        n = 0;
        while (pm_addr != 4'd4 && n < 20) begin
            restart = (n == 0);
            top_up();
            @(posedge clk);
            #1;
            restart = 1'b0;
            n++;
        end
        chk("reach_addr4", 32'(pm_addr), 4);
        stall = 1'b1;
        repeat (3) begin
            top_up();
            @(posedge clk);
            #1;
            chk("stall_beats_halt", 32'(halted), 0);
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("halt_after_stall", 32'({halted, ins_valid, pc, pm_addr}), 32'({1'b1, 1'b0, 4'd4, 4'd4}));
        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that feeds the instruction decoder. It holds the program counter and drives the synchronous program-memory address. It registers each 13-bit fetched word into the instruction register presented to the decoder, and qualifies it with a valid flag. It supports a stall from downstream, wrap-around of the program address space, and a HALT opcode that stops fetching until a restart pulse.

## Interface
Parameters:
- `INS_W`, 13: instruction width; opcode is `ins[INS_W-1:INS_W-5]`.
- `PM_DEPTH`, 256: number of program-memory words; need not be a power of two.
- `ADDR_W`, `$clog2(PM_DEPTH)`: program-address width.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `en`  in  1  start request; sampled only in IDLE.
- `stall`  in  1  downstream hold; freezes the fetch pipeline in RUN.
- `restart`  in  1  single-cycle pulse; leaves HALT; ignored in any other state.
- `pm_addr`  out  ADDR_W  program-memory read address (equals the `fetch_addr` register).
- `pm_rdata`  in  INS_W  program-memory data; one-cycle read latency from `pm_addr`.
- `ins`  out  INS_W  instruction register, drives the decoder's `Ins`.
- `ins_valid`  out  1  `ins` is a live instruction; the top level gates all decoder CE strobes with it.
- `pc`  out  ADDR_W  address of the instruction currently in `ins`.
- `halted`  out  1  block is in HALT.

## Operation
- Registers: `state`, `fetch_addr`, `ins`, `pc`, `ins_valid`, `halted`.
- Reset values: state=IDLE, `fetch_addr`=0, `ins`=0, `pc`=0, `ins_valid`=0, `halted`=0. `pm_addr`=0.
- Reset mid-operation: all registers return to their reset values on the next edge, whatever the state.
- Load event: updates `ins`<=`pm_rdata`, `pc`<=`fetch_addr`, and `fetch_addr`<=inc(`fetch_addr`).
- inc(a): a+1, except PM_DEPTH-1 -> 0 (wrap-around, explicit compare).
- HALT opcode: `OPCODE_HALT` = 5'b11111 (REST section, sub-code 7; unused by LD/ST).
- FSM:
  - IDLE: `fetch_addr` held at 0. `en`=1 -> PRIME.
  - PRIME: one cycle; memory returns word 0. `stall` is ignored. At exit: load event, `ins_valid`<=1, -> RUN.
  - RUN, `stall`=1: no load; `ins`, `pc`, `fetch_addr` and `ins_valid` hold. The memory re-reads the same address, so `pm_rdata` stays consistent.
  - RUN, `stall`=0 and `pm_rdata` opcode ≠ HALT: load event, stay in RUN.
  - RUN, `stall`=0 and `pm_rdata` opcode = HALT: `ins`<=`pm_rdata` and `pc`<=`fetch_addr`, but `fetch_addr` holds. `ins_valid`<=0, `halted`<=1, -> HALT.
  - HALT: all registers hold. `restart`=1 -> `fetch_addr`<=0, `halted`<=0, `ins_valid`<=0, -> PRIME.
- Simultaneous events:
  - `stall` together with a HALT word on `pm_rdata`: stall wins, no halt detect that cycle.
  - `restart` outside HALT: no effect.
  - `en` outside IDLE: no effect.
- A HALT word is never presented with `ins_valid`=1.

## Timing
- Start latency: `en` sampled high at edge k -> PRIME at k -> `ins` = mem[0] with `ins_valid`=1 after edge k+1.
- Throughput: one instruction per cycle in RUN with `stall`=0.
- Stall: 0-cycle response; the instruction in `ins` stays visible for every stalled cycle plus one.
- HALT: takes effect on the edge that would have loaded the HALT word. `ins_valid` falls on that same edge.
- Restart latency: `restart` at edge r -> PRIME -> mem[0] valid after edge r+1.
- `pm_addr` is a registered output; no combinational path from inputs to outputs.

## Structure
- Shared package `uproc_pkg`: `OPCODE_HALT`; state enum `fetch_state_t` {IDLE, PRIME, RUN, HALT}; default `PM_DEPTH`; `INS_W`. These join the existing OPCODE_/SEC_/ALU_ constants.
- Sub-module `program_counter`: `fetch_addr` register with clear, load-enable and parameterized wrap. The FSM and instruction register stay in the top module.

## Test plan
- Reset then start: `rst_n`=0 for 2 cycles, `en`=1. Expect `pm_addr`=0 during reset; `ins_valid`=1 with `pc`=0 and `ins`=mem[0] two edges after `en`; then `pc`=1, 2, 3 on consecutive cycles.
- Stall: in RUN with `pc`=5, hold `stall`=1 for 3 cycles. Expect `ins`=mem[5], `pc`=5, `pm_addr`=6 held for 3 cycles; `pc`=6 on the first unstalled edge.
- Wrap-around: `PM_DEPTH`=6, no HALT words. Expect the `pc` sequence 4, 5, 0, 1 and `pm_addr` 5 -> 0 -> 1.
- HALT and restart: mem[3]=13'h1F00. Expect `pc`=3, `ins_valid`=0, `halted`=1, `pm_addr`=3 frozen. Pulse `restart`: expect `halted`=0, then `pc`=0 valid two edges later.
- Priority: mem[4]=HALT with `stall`=1 while `pm_addr`=4. Expect no halt until `stall` drops, then HALT on the next edge. `restart` pulsed in RUN has no effect.
- Reset mid-run: `rst_n`=0 for one edge at `pc`=7. Expect all outputs at reset values, state IDLE, no fetch until `en`.
